arp_tx_framer: RTL and testbench

//  Transmit-side counterpart of the ARP receive status block. Host software writes Ethernet/ARP

---
 rtl/arp_tx_framer_if.sv | 26 ++
 rtl/arp_tx_framer.sv | 243 ++++++++++++++++++++++++
 tb/tb_arp_tx_framer.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_tx_framer_if.sv
// Command-port and TX byte-stream bundle for arp_tx_framer.
// The framer is the slave of the command port and the source of the byte stream.
interface arp_tx_framer_if;
  logic [7:0]  i_tx_cmd_addr;
  logic [31:0] i_tx_pkt_data;
  logic        i_tx_pkt_wr;
  logic [31:0] o_tx_pkt_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_tx_sop;
  logic        o_tx_eop;
  logic        o_busy;

  // Host/MAC side: issues commands and ready, observes readback and the stream.
  modport master (
    output i_tx_cmd_addr, i_tx_pkt_data, i_tx_pkt_wr, i_tx_ready,
    input  o_tx_pkt_data, o_tx_data, o_tx_valid, o_tx_sop, o_tx_eop, o_busy
  );

  // Framer side.
  modport slave (
    input  i_tx_cmd_addr, i_tx_pkt_data, i_tx_pkt_wr, i_tx_ready,
    output o_tx_pkt_data, o_tx_data, o_tx_valid, o_tx_sop, o_tx_eop, o_busy
  );
endinterface

// File: rtl/arp_tx_framer.sv
// arp_tx_framer: host-programmed Ethernet+ARP frame generator.
// Fields are written through an address/data port; a START write launches one
// FRAME_LEN-byte frame (no FCS) on a valid/ready byte stream, after which an
// inter-frame gap of IFG_CYCLES clocks is enforced before START is honoured again.
module arp_tx_framer #(
  parameter int FRAME_LEN  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic           clk,
  input  logic           rst,
  arp_tx_framer_if.slave bus
);

  localparam int               GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [6:0]       LAST_IDX = 7'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  localparam logic [7:0] A_DST_LO = 8'h01;
  localparam logic [7:0] A_DST_HI = 8'h02;
  localparam logic [7:0] A_SRC_LO = 8'h03;
  localparam logic [7:0] A_SRC_HI = 8'h04;
  localparam logic [7:0] A_OPER   = 8'h05;
  localparam logic [7:0] A_SHA_LO = 8'h06;
  localparam logic [7:0] A_SHA_HI = 8'h07;
  localparam logic [7:0] A_SPA    = 8'h08;
  localparam logic [7:0] A_THA_LO = 8'h09;
  localparam logic [7:0] A_THA_HI = 8'h0A;
  localparam logic [7:0] A_TPA    = 8'h0B;
  localparam logic [7:0] A_START  = 8'h0C;
  localparam logic [7:0] A_STAT   = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [6:0]       r_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [15:0]      r_frame_cnt;

  logic [47:0]      r_dst_mac;
  logic [47:0]      r_src_mac;
  logic [1:0]       r_oper;
  logic [47:0]      r_sha;
  logic [31:0]      r_spa;
  logic [47:0]      r_tha;
  logic [31:0]      r_tpa;

  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_tx_sop;
  logic             r_tx_eop;
  logic             r_busy;

  logic             w_idle;
  logic             w_field_wr;
  logic             w_start;
  logic [6:0]       w_next_idx;
  logic [7:0]       w_next_byte;

  // Fields are only writable while idle, so they stay frozen for a whole frame.
  assign w_idle     = (r_state == S_IDLE);
  assign w_field_wr = bus.i_tx_pkt_wr && w_idle;
  assign w_start    = w_field_wr && (bus.i_tx_cmd_addr == A_START) && bus.i_tx_pkt_data[0];
  // Index of the byte to present after the next edge: 0 on launch, idx+1 while sending.
  assign w_next_idx = (r_state == S_SEND) ? (r_idx + 7'd1) : 7'd0;

  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_tx_sop   = r_tx_sop;
  assign bus.o_tx_eop   = r_tx_eop;
  assign bus.o_busy     = r_busy;

  // Frame byte selector: header/ARP layout in network order, zero pad beyond byte 41.
  always_comb begin
    w_next_byte = 8'h00;
    case (w_next_idx)
      7'd0:    w_next_byte = r_dst_mac[47:40];
      7'd1:    w_next_byte = r_dst_mac[39:32];
      7'd2:    w_next_byte = r_dst_mac[31:24];
      7'd3:    w_next_byte = r_dst_mac[23:16];
      7'd4:    w_next_byte = r_dst_mac[15:8];
      7'd5:    w_next_byte = r_dst_mac[7:0];
      7'd6:    w_next_byte = r_src_mac[47:40];
      7'd7:    w_next_byte = r_src_mac[39:32];
      7'd8:    w_next_byte = r_src_mac[31:24];
      7'd9:    w_next_byte = r_src_mac[23:16];
      7'd10:   w_next_byte = r_src_mac[15:8];
      7'd11:   w_next_byte = r_src_mac[7:0];
      7'd12:   w_next_byte = 8'h08;
      7'd13:   w_next_byte = 8'h06;
      7'd14:   w_next_byte = 8'h00;
      7'd15:   w_next_byte = 8'h01;
      7'd16:   w_next_byte = 8'h08;
      7'd17:   w_next_byte = 8'h00;
      7'd18:   w_next_byte = 8'h06;
      7'd19:   w_next_byte = 8'h04;
      7'd20:   w_next_byte = 8'h00;
      7'd21:   w_next_byte = {6'd0, r_oper};
      7'd22:   w_next_byte = r_sha[47:40];
      7'd23:   w_next_byte = r_sha[39:32];
      7'd24:   w_next_byte = r_sha[31:24];
      7'd25:   w_next_byte = r_sha[23:16];
      7'd26:   w_next_byte = r_sha[15:8];
      7'd27:   w_next_byte = r_sha[7:0];
      7'd28:   w_next_byte = r_spa[31:24];
      7'd29:   w_next_byte = r_spa[23:16];
      7'd30:   w_next_byte = r_spa[15:8];
      7'd31:   w_next_byte = r_spa[7:0];
      7'd32:   w_next_byte = r_tha[47:40];
      7'd33:   w_next_byte = r_tha[39:32];
      7'd34:   w_next_byte = r_tha[31:24];
      7'd35:   w_next_byte = r_tha[23:16];
      7'd36:   w_next_byte = r_tha[15:8];
      7'd37:   w_next_byte = r_tha[7:0];
      7'd38:   w_next_byte = r_tpa[31:24];
      7'd39:   w_next_byte = r_tpa[23:16];
      7'd40:   w_next_byte = r_tpa[15:8];
      7'd41:   w_next_byte = r_tpa[7:0];
      default: w_next_byte = 8'h00;
    endcase
  end

  // Field registers: loaded from the command port while idle, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst_mac <= 48'd0;
      r_src_mac <= 48'd0;
      r_oper    <= 2'd0;
      r_sha     <= 48'd0;
      r_spa     <= 32'd0;
      r_tha     <= 48'd0;
      r_tpa     <= 32'd0;
    end else if (w_field_wr) begin
      case (bus.i_tx_cmd_addr)
        A_DST_LO: r_dst_mac[31:0]  <= bus.i_tx_pkt_data;
        A_DST_HI: r_dst_mac[47:32] <= bus.i_tx_pkt_data[15:0];
        A_SRC_LO: r_src_mac[31:0]  <= bus.i_tx_pkt_data;
        A_SRC_HI: r_src_mac[47:32] <= bus.i_tx_pkt_data[15:0];
        A_OPER:   r_oper           <= bus.i_tx_pkt_data[1:0];
        A_SHA_LO: r_sha[31:0]      <= bus.i_tx_pkt_data;
        A_SHA_HI: r_sha[47:32]     <= bus.i_tx_pkt_data[15:0];
        A_SPA:    r_spa            <= bus.i_tx_pkt_data;
        A_THA_LO: r_tha[31:0]      <= bus.i_tx_pkt_data;
        A_THA_HI: r_tha[47:32]     <= bus.i_tx_pkt_data[15:0];
        A_TPA:    r_tpa            <= bus.i_tx_pkt_data;
        default:  ;
      endcase
    end
  end

  // Frame sequencer: launch on START, advance on each accepted byte, then hold off for the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 7'd0;
      r_gap_cnt   <= '0;
      r_frame_cnt <= 16'd0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_tx_sop    <= 1'b0;
      r_tx_eop    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_SEND;
            r_idx      <= 7'd0;
            r_tx_data  <= w_next_byte;
            r_tx_valid <= 1'b1;
            r_tx_sop   <= 1'b1;
            r_tx_eop   <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_SEND: begin
          // Valid is held high throughout SEND, so acceptance is just ready.
          if (bus.i_tx_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state     <= S_GAP;
              r_idx       <= 7'd0;
              r_gap_cnt   <= '0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_tx_data   <= 8'h00;
              r_tx_valid  <= 1'b0;
              r_tx_sop    <= 1'b0;
              r_tx_eop    <= 1'b0;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
              r_tx_sop  <= 1'b0;
              r_tx_eop  <= (w_next_idx == LAST_IDX);
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_ONE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_idx      <= 7'd0;
          r_gap_cnt  <= '0;
          r_tx_data  <= 8'h00;
          r_tx_valid <= 1'b0;
          r_tx_sop   <= 1'b0;
          r_tx_eop   <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Readback mux: same packing as the RX status block, upper bits zero.
  always_comb begin
    bus.o_tx_pkt_data = 32'd0;
    case (bus.i_tx_cmd_addr)
      A_DST_LO: bus.o_tx_pkt_data = r_dst_mac[31:0];
      A_DST_HI: bus.o_tx_pkt_data = {16'd0, r_dst_mac[47:32]};
      A_SRC_LO: bus.o_tx_pkt_data = r_src_mac[31:0];
      A_SRC_HI: bus.o_tx_pkt_data = {16'd0, r_src_mac[47:32]};
      A_OPER:   bus.o_tx_pkt_data = {30'd0, r_oper};
      A_SHA_LO: bus.o_tx_pkt_data = r_sha[31:0];
      A_SHA_HI: bus.o_tx_pkt_data = {16'd0, r_sha[47:32]};
      A_SPA:    bus.o_tx_pkt_data = r_spa;
      A_THA_LO: bus.o_tx_pkt_data = r_tha[31:0];
      A_THA_HI: bus.o_tx_pkt_data = {16'd0, r_tha[47:32]};
      A_TPA:    bus.o_tx_pkt_data = r_tpa;
      A_STAT:   bus.o_tx_pkt_data = {15'd0, r_busy, r_frame_cnt};
      default:  bus.o_tx_pkt_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_arp_tx_framer.sv
// Bench for arp_tx_framer: directed scenarios plus randomized traffic, checked every
// cycle against a frame-level model (register shadow, byte queue, gap countdown).
module tb_arp_tx_framer;
  localparam int FRAME_LEN = 60;
  localparam int IFG       = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;

  arp_tx_framer_if bus ();

  arp_tx_framer #(.FRAME_LEN(FRAME_LEN), .IFG_CYCLES(IFG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state
  logic [31:0] m_reg [1:11];
  logic [7:0]  m_q [$];
  bit          m_sending;
  int          m_pos;
  int          m_gap_left;
  logic [15:0] m_cnt;

  // Captured accepted bytes
  logic [7:0]  cap [$];
  bit          cap_sop [$];
  bit          cap_eop [$];
  int          cap_cyc [$];
  logic [7:0]  gold [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] field_mask(input int a);
    case (a)
      2, 4, 7, 10: return 32'h0000_FFFF;
      5:           return 32'h0000_0003;
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 1; i <= 11; i++) m_reg[i] = 32'd0;
    m_q.delete();
    m_sending  = 1'b0;
    m_pos      = 0;
    m_gap_left = 0;
    m_cnt      = 16'd0;
  endtask

  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) m_q.push_back(v[8*i +: 8]);
  endtask

  task automatic build_frame();
    m_q.delete();
    push_be({m_reg[2][15:0], m_reg[1]}, 6);
    push_be({m_reg[4][15:0], m_reg[3]}, 6);
    push_be(48'h0806, 2);
    push_be(48'h0001, 2);
    push_be(48'h0800, 2);
    push_be(48'h0604, 2);
    push_be({46'd0, m_reg[5][1:0]}, 2);
    push_be({m_reg[7][15:0], m_reg[6]}, 6);
    push_be({16'd0, m_reg[8]}, 4);
    push_be({m_reg[10][15:0], m_reg[9]}, 6);
    push_be({16'd0, m_reg[11]}, 4);
    while (m_q.size() < FRAME_LEN) m_q.push_back(8'h00);
  endtask

  // Advance the model across one rising edge using the inputs presented to it.
  task automatic model_step();
    int a;
    a = int'(bus.i_tx_cmd_addr);
    if (rst) begin
      model_reset();
    end else if (m_sending) begin
      if (bus.i_tx_ready) begin
        if (m_pos == FRAME_LEN - 1) begin
          m_sending  = 1'b0;
          m_gap_left = IFG;
          m_cnt      = m_cnt + 16'd1;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end else if (m_gap_left > 0) begin
      m_gap_left = m_gap_left - 1;
    end else if (bus.i_tx_pkt_wr) begin
      if (a >= 1 && a <= 11) begin
        m_reg[a] = bus.i_tx_pkt_data & field_mask(a);
      end else if (a == 12 && bus.i_tx_pkt_data[0]) begin
        build_frame();
        m_sending = 1'b1;
        m_pos     = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [7:0] addr);
    int a;
    a = int'(addr);
    if (a >= 1 && a <= 11) return m_reg[a];
    else if (a == 13) return {15'd0, (m_sending || m_gap_left > 0), m_cnt};
    else return 32'd0;
  endfunction

  // Per-cycle compare on the falling edge, plus capture of bytes about to be accepted.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      check("tx_valid", 32'(bus.o_tx_valid), 32'(m_sending));
      check("tx_data",  32'(bus.o_tx_data),  32'(m_sending ? m_q[m_pos] : 8'h00));
      check("tx_sop",   32'(bus.o_tx_sop),   32'(m_sending && m_pos == 0));
      check("tx_eop",   32'(bus.o_tx_eop),   32'(m_sending && m_pos == FRAME_LEN - 1));
      check("busy",     32'(bus.o_busy),     32'(m_sending || m_gap_left > 0));
      check("readback", bus.o_tx_pkt_data,   exp_rd(bus.i_tx_cmd_addr));
      if (!rst && bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1) begin
        cap.push_back(bus.o_tx_data);
        cap_sop.push_back(bus.o_tx_sop);
        cap_eop.push_back(bus.o_tx_eop);
        cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.i_tx_cmd_addr = a;
    bus.i_tx_pkt_data = d;
    bus.i_tx_pkt_wr   = 1'b1;
    tick();
    bus.i_tx_pkt_wr   = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [31:0] exp, input string name);
    bus.i_tx_cmd_addr = a;
    tick();
    check(name, bus.o_tx_pkt_data, exp);
  endtask

  task automatic clear_cap();
    cap.delete();
    cap_sop.delete();
    cap_eop.delete();
    cap_cyc.delete();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.o_busy !== 1'b0 && k < 400) begin
      tick();
      k++;
    end
    check(name, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic run_bytes(input int n, input bit toggle, input string name);
    int k;
    k = 0;
    while (cap.size() < n && k < 400) begin
      if (toggle) bus.i_tx_ready = ~bus.i_tx_ready;
      tick();
      k++;
    end
    check(name, 32'(cap.size()), 32'(n));
  endtask

  // Reset asserted in the middle of a clock period; outputs must clear at once.
  task automatic async_reset(input string pfx);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check({pfx, "_valid"}, 32'(bus.o_tx_valid), 32'd0);
    check({pfx, "_data"},  32'(bus.o_tx_data),  32'd0);
    check({pfx, "_sop"},   32'(bus.o_tx_sop),   32'd0);
    check({pfx, "_eop"},   32'(bus.o_tx_eop),   32'd0);
    check({pfx, "_busy"},  32'(bus.o_busy),     32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int diffs;
    int ones;
    int last;
    logic [7:0]  pad_or;
    logic [63:0] hdr;
    logic [7:0]  e;

    bus.i_tx_cmd_addr = 8'h00;
    bus.i_tx_pkt_data = 32'd0;
    bus.i_tx_pkt_wr   = 1'b0;
    bus.i_tx_ready    = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    // 1: reset mid-frame
    bus.i_tx_ready = 1'b1;
    wr(8'h01, 32'hDEAD_BEEF);
    wr(8'h0C, 32'h1);
    tick(); tick(); tick(); tick();
    async_reset("rst1");
    rd_check(8'h0D, 32'd0, "rd0D_after_rst");
    rd_check(8'h01, 32'd0, "rd01_after_rst");

    // 2: broadcast ARP reply, ready always high
    wr(8'h01, 32'hFFFF_FFFF);
    wr(8'h02, 32'h0000_FFFF);
    wr(8'h03, 32'h0000_0001);
    wr(8'h04, 32'h0000_0200);
    wr(8'h05, 32'h0000_0002);
    wr(8'h08, 32'hC0A8_0001);
    wr(8'h0B, 32'hC0A8_0002);
    clear_cap();
    bus.i_tx_ready = 1'b1;
    wr(8'h0C, 32'h1);
    check("start_lat_valid", 32'(bus.o_tx_valid), 32'd1);
    check("start_lat_sop",   32'(bus.o_tx_sop),   32'd1);
    check("start_lat_data",  32'(bus.o_tx_data),  32'h0000_00FF);
    run_bytes(FRAME_LEN, 1'b0, "frame2_len");
    if (cap.size() == FRAME_LEN) begin
      check("f2_b0",  32'(cap[0]),  32'h0000_00FF);
      check("f2_b6",  32'(cap[6]),  32'h0000_0002);
      check("f2_b11", 32'(cap[11]), 32'h0000_0001);
      check("f2_b12", 32'(cap[12]), 32'h0000_0008);
      check("f2_b13", 32'(cap[13]), 32'h0000_0006);
      check("f2_b21", 32'(cap[21]), 32'h0000_0002);
      check("f2_b28", 32'(cap[28]), 32'h0000_00C0);
      check("f2_b41", 32'(cap[41]), 32'h0000_0002);
      pad_or = 8'h00;
      for (int i = 42; i < FRAME_LEN; i++) pad_or = pad_or | cap[i];
      check("f2_pad", 32'(pad_or), 32'd0);
      ones = 0;
      for (int i = 0; i < FRAME_LEN; i++) ones += int'(cap_sop[i]) + int'(cap_eop[i]);
      check("f2_sop0", 32'(cap_sop[0]), 32'd1);
      check("f2_eop59", 32'(cap_eop[FRAME_LEN-1]), 32'd1);
      check("f2_marks", 32'(ones), 32'd2);
      check("f2_consec", 32'(cap_cyc[FRAME_LEN-1] - cap_cyc[0]), 32'(FRAME_LEN - 1));
    end
    gold = cap;

    // 3: same frame with ready toggling every cycle
    wait_idle("idle_before3");
    clear_cap();
    bus.i_tx_ready = 1'b0;
    wr(8'h0C, 32'h1);
    run_bytes(FRAME_LEN, 1'b1, "frame3_len");
    if (cap.size() == FRAME_LEN && gold.size() == FRAME_LEN) begin
      diffs = 0;
      for (int i = 0; i < FRAME_LEN; i++) if (cap[i] !== gold[i]) diffs++;
      check("frame3_same", 32'(diffs), 32'd0);
    end

    // 4: START and field writes during SEND and GAP are ignored; gap length
    wait_idle("idle_before4");
    clear_cap();
    bus.i_tx_ready = 1'b1;
    wr(8'h0C, 32'h1);
    tick(); tick(); tick(); tick(); tick();
    wr(8'h08, 32'h1111_1111);
    wr(8'h0C, 32'h1);
    run_bytes(FRAME_LEN, 1'b0, "frame4_len");
    wr(8'h08, 32'h2222_2222);
    wr(8'h0C, 32'h1);
    begin
      int k;
      k = 0;
      while (bus.o_busy === 1'b1 && k < 40) begin
        tick();
        k++;
      end
    end
    last = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : 0;
    check("gap_len", 32'(cyc - last), 32'(IFG));
    rd_check(8'h08, 32'hC0A8_0001, "rd08_unchanged");
    rd_check(8'h0D, 32'h0000_0003, "rd0D_three");

    // 5: reset at byte 20, then a fresh frame with all fields zero
    clear_cap();
    wr(8'h0C, 32'h1);
    run_bytes(20, 1'b0, "frame5_pre");
    async_reset("rst2");
    clear_cap();
    bus.i_tx_ready = 1'b1;
    wr(8'h0C, 32'h1);
    run_bytes(FRAME_LEN, 1'b0, "frame5_len");
    if (cap.size() == FRAME_LEN) begin
      hdr = 64'h0806_0001_0800_0604;
      diffs = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        e = (i >= 12 && i <= 19) ? hdr[8*(19-i) +: 8] : 8'h00;
        if (cap[i] !== e) diffs++;
      end
      check("frame5_zero", 32'(diffs), 32'd0);
    end

    // 6: two back-to-back frames after reset, then readback of status and unmapped addresses
    wait_idle("idle_before6");
    async_reset("rst3");
    bus.i_tx_ready = 1'b1;
    wr(8'h0C, 32'h1);
    wait_idle("idle_6a");
    wr(8'h0C, 32'h1);
    wait_idle("idle_6b");
    rd_check(8'h0D, 32'h0000_0002, "rd0D_two");
    rd_check(8'h0C, 32'd0, "rd0C_zero");
    rd_check(8'h0E, 32'd0, "rd0E_zero");
    rd_check(8'hFF, 32'd0, "rdFF_zero");

    // Randomized traffic: random field writes, random ready, stray writes during frames
    for (int f = 0; f < 8; f++) begin
      for (int w = 0; w < 10; w++) wr(8'($urandom_range(0, 15)), $urandom());
      bus.i_tx_ready = 1'b1;
      wr(8'h0C, 32'h1);
      for (int k = 0; k < 160; k++) begin
        bus.i_tx_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          bus.i_tx_cmd_addr = 8'($urandom_range(0, 15));
          bus.i_tx_pkt_data = $urandom();
          bus.i_tx_pkt_wr   = 1'b1;
        end else begin
          bus.i_tx_pkt_wr   = 1'b0;
        end
        tick();
      end
      bus.i_tx_pkt_wr = 1'b0;
    end
    bus.i_tx_ready = 1'b1;
    wait_idle("idle_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
